// File: rtl/brisc_trap_ctrl.sv
// rtl/brisc_trap_ctrl.sv - privilege mode, trap entry/return and boot redirect controller
module brisc_trap_ctrl #(
    parameter int                CAUSE_NUM_DUMMY = 0,
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   BOOT_PC    = 32'h00001000,
    parameter logic [XLEN-1:0]   EXCEPT_PC  = 32'h00002000,
    parameter int                NUM_CAUSES = 4,
    parameter int                CAUSE_W    = $clog2(NUM_CAUSES),
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               except_valid_i,
    input  logic [CAUSE_W-1:0] except_cause_i,
    input  logic [XLEN-1:0]    except_pc_i,
    input  logic [XLEN-1:0]    except_addr_i,
    input  logic               iret_i,
    input  logic               rm0_we_i,
    input  logic [XLEN-1:0]    rm0_wdata_i,
    output logic               priv_mode_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               flush_o,
    output logic [XLEN-1:0]    rm0_o,
    output logic [XLEN-1:0]    rm1_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   trap_count_o
);

    typedef enum logic [2:0] {BOOT, SUP, USER, TRAP, RET, HALT} state_t;

    localparam logic [CAUSE_W:0]   NUM_C     = (CAUSE_W+1)'(NUM_CAUSES);
    localparam logic [CAUSE_W-1:0] MAX_CAUSE = CAUSE_W'(NUM_CAUSES - 1);

    state_t             state_q, state_d;
    logic               priv_q, priv_d;
    logic               redir_v_q, redir_v_d;
    logic [XLEN-1:0]    redir_pc_q, redir_pc_d;
    logic [XLEN-1:0]    rm0_q, rm0_d;
    logic [XLEN-1:0]    rm1_q, rm1_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_take;
    logic [CAUSE_W-1:0] cause_clamped;

    always_comb begin
        cause_clamped = ({1'b0, except_cause_i} >= NUM_C) ? MAX_CAUSE : except_cause_i;
        trap_take     = except_valid_i && (state_q == SUP || state_q == USER);

        state_d    = state_q;
        priv_d     = priv_q;
        redir_v_d  = 1'b0;
        redir_pc_d = redir_pc_q;
        rm0_d      = rm0_q;
        rm1_d      = rm1_q;
        cause_d    = cause_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        case (state_q)
            BOOT: begin
                state_d    = SUP;
                priv_d     = 1'b1;
                redir_v_d  = 1'b1;
                redir_pc_d = BOOT_PC;
            end
            SUP: begin
                if (rm0_we_i) rm0_d = rm0_wdata_i;
                if (except_valid_i) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    priv_d   = 1'b1;
                end else if (iret_i) begin
                    state_d    = RET;
                    priv_d     = 1'b0;
                    redir_v_d  = 1'b1;
                    redir_pc_d = rm0_d;
                end
            end
            USER: begin
                if (except_valid_i) begin
                    state_d    = TRAP;
                    priv_d     = 1'b1;
                    redir_v_d  = 1'b1;
                    redir_pc_d = EXCEPT_PC;
                end
            end
            TRAP:    state_d = SUP;
            RET:     state_d = USER;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        // Trap capture overrides any same-cycle software write of rm0.
        if (trap_take) begin
            rm0_d   = except_pc_i;
            rm1_d   = except_addr_i;
            cause_d = cause_clamped;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            priv_q     <= 1'b1;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
            rm0_q      <= '0;
            rm1_q      <= '0;
            cause_q    <= '0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            priv_q     <= priv_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            rm0_q      <= rm0_d;
            rm1_q      <= rm1_d;
            cause_q    <= cause_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign priv_mode_o      = priv_q;
    assign redirect_valid_o = redir_v_q;
    assign flush_o          = redir_v_q;
    assign redirect_pc_o    = redir_pc_q;
    assign rm0_o            = rm0_q;
    assign rm1_o            = rm1_q;
    assign cause_o          = cause_q;
    assign halted_o         = halted_q;
    assign trap_count_o     = cnt_q;

endmodule

// File: tb/tb_brisc_trap_ctrl.sv
// tb/tb_brisc_trap_ctrl.sv - directed bench for brisc_trap_ctrl (default and 5-cause/2-bit-counter builds)
module tb_brisc_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        except_valid;
    logic [2:0]  cause3;
    logic [31:0] except_pc, except_addr, rm0_wdata;
    logic        iret, rm0_we;

    logic        a_priv, a_rv, a_flush, a_halt;
    logic [31:0] a_rpc, a_rm0, a_rm1;
    logic [1:0]  a_cause;
    logic [15:0] a_cnt;

    logic        b_priv, b_rv, b_flush, b_halt;
    logic [31:0] b_rpc, b_rm0, b_rm1;
    logic [2:0]  b_cause;
    logic [1:0]  b_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    brisc_trap_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .except_valid_i(except_valid), .except_cause_i(cause3[1:0]),
        .except_pc_i(except_pc), .except_addr_i(except_addr), .iret_i(iret), .rm0_we_i(rm0_we),
        .rm0_wdata_i(rm0_wdata), .priv_mode_o(a_priv), .redirect_valid_o(a_rv), .redirect_pc_o(a_rpc),
        .flush_o(a_flush), .rm0_o(a_rm0), .rm1_o(a_rm1), .cause_o(a_cause), .halted_o(a_halt),
        .trap_count_o(a_cnt)
    );

    brisc_trap_ctrl #(.NUM_CAUSES(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .except_valid_i(except_valid), .except_cause_i(cause3),
        .except_pc_i(except_pc), .except_addr_i(except_addr), .iret_i(iret), .rm0_we_i(rm0_we),
        .rm0_wdata_i(rm0_wdata), .priv_mode_o(b_priv), .redirect_valid_o(b_rv), .redirect_pc_o(b_rpc),
        .flush_o(b_flush), .rm0_o(b_rm0), .rm1_o(b_rm1), .cause_o(b_cause), .halted_o(b_halt),
        .trap_count_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        except_valid = 1'b0; iret = 1'b0; rm0_we = 1'b0;
    endtask

    task automatic redir(input string tag, input logic [31:0] pc, input logic priv);
        chk({tag, "_rv_a"}, a_rv, 1'b1);
        chk({tag, "_flush_a"}, a_flush, 1'b1);
        chk({tag, "_pc_a"}, a_rpc, pc);
        chk({tag, "_priv_a"}, a_priv, priv);
        chk({tag, "_rv_b"}, b_rv, 1'b1);
        chk({tag, "_pc_b"}, b_rpc, pc);
    endtask

    task automatic trap(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] addr);
        except_valid = 1'b1; cause3 = c; except_pc = pc; except_addr = addr;
        step();
        idle();
    endtask

    task automatic do_iret();
        iret = 1'b1;
        step();
        idle();
    endtask

    initial begin
        rst_n = 1'b0; idle();
        cause3 = '0; except_pc = '0; except_addr = '0; rm0_wdata = '0;
        step(); step();
        chk("rst_rv", a_rv, 1'b0);
        chk("rst_pc", a_rpc, 32'h0);
        chk("rst_priv", a_priv, 1'b1);
        chk("rst_rm0", a_rm0, 32'h0);
        chk("rst_halt", a_halt, 1'b0);
        chk("rst_cnt", a_cnt, 16'h0);

        rst_n = 1'b1;
        step();
        redir("boot", 32'h1000, 1'b1);
        step();
        chk("boot_done_rv", a_rv, 1'b0);
        chk("boot_done_pc_hold", a_rpc, 32'h1000);

        rm0_we = 1'b1; rm0_wdata = 32'h3000;
        step(); idle();
        chk("rm0_wr", a_rm0, 32'h3000);
        do_iret();
        redir("iret1", 32'h3000, 1'b0);
        step();
        chk("user_rv", a_rv, 1'b0);
        chk("user_priv", a_priv, 1'b0);

        trap(3'd2, 32'h3010, 32'hDEAD0000);
        redir("trap1", 32'h2000, 1'b1);
        chk("trap1_rm0", a_rm0, 32'h3010);
        chk("trap1_rm1", a_rm1, 32'hDEAD0000);
        chk("trap1_cause", a_cause, 2'd2);
        chk("trap1_cnt_a", a_cnt, 16'd1);
        chk("trap1_cnt_b", b_cnt, 2'd1);
        step();
        chk("sup_rv", a_rv, 1'b0);
        chk("sup_priv", a_priv, 1'b1);

        do_iret();
        redir("iret2", 32'h3010, 1'b0);
        step();
        iret = 1'b1; rm0_we = 1'b1; rm0_wdata = 32'h7777;
        step(); idle();
        chk("user_iret_ign_rv", a_rv, 1'b0);
        chk("user_iret_ign_priv", a_priv, 1'b0);
        chk("user_we_ign", a_rm0, 32'h3010);

        iret = 1'b1;
        trap(3'd7, 32'h3020, 32'h44);
        redir("trap2", 32'h2000, 1'b1);
        chk("clamp_a", a_cause, 2'd3);
        chk("clamp_b", b_cause, 3'd4);
        chk("trap2_cnt_a", a_cnt, 16'd2);
        step();
        do_iret();
        redir("iret3", 32'h3020, 1'b0);
        step();

        trap(3'd1, 32'h3030, 32'h55);
        chk("trap3_cnt_b", b_cnt, 2'd3);
        step(); do_iret(); step();
        trap(3'd1, 32'h3040, 32'h66);
        chk("sat_cnt_a", a_cnt, 16'd4);
        chk("sat_cnt_b", b_cnt, 2'd3);
        step(); do_iret(); step();

        trap(3'd0, 32'h3050, 32'h77);
        chk("mid_trap_rv", a_rv, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rv", a_rv, 1'b0);
        chk("async_flush", a_flush, 1'b0);
        chk("async_cnt", a_cnt, 16'd0);
        chk("async_rm0", a_rm0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        redir("reboot", 32'h1000, 1'b1);
        step();

        rm0_we = 1'b1; rm0_wdata = 32'h9999;
        trap(3'd1, 32'h4000, 32'h4444);
        chk("halt_flag", a_halt, 1'b1);
        chk("halt_rv", a_rv, 1'b0);
        chk("halt_priv", a_priv, 1'b1);
        chk("halt_rm0", a_rm0, 32'h4000);
        chk("halt_rm1", a_rm1, 32'h4444);
        chk("halt_cause", a_cause, 2'd1);
        chk("halt_cnt", a_cnt, 16'd1);
        do_iret();
        chk("halt_iret_rv", a_rv, 1'b0);
        trap(3'd2, 32'h5000, 32'h5555);
        chk("halt_exc_rv", a_rv, 1'b0);
        chk("halt_exc_rm0", a_rm0, 32'h4000);
        chk("halt_exc_cnt", a_cnt, 16'd1);
        chk("halt_stay", b_halt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("halt_clear", a_halt, 1'b0);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
